// File: rtl/mux_arb_param_pkg.sv
// Shared types for the arbitrated N-to-1 registered mux: payload types carried by
// the channels, the arbitration mode selector and the round-robin pointer step.
package mux_arb_param_pkg;

    typedef enum logic [2:0] {
        OP_NOP, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_JMP
    } op_codes_e_t;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [3:0] be;
    } mem_ctl_st_t;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e_t;

    typedef enum logic {EMPTY, FULL} out_state_e;

    function automatic int unsigned next_rr_ptr(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 32'd0 : w + 1;
    endfunction

endpackage

// File: rtl/mux_arb_param_if.sv
// Channel-side and consumer-side handshake bundle of the arbitrated mux.
// The mux sits on the slave modport; producers/consumer drive the master modport.
interface mux_arb_param_if
    import mux_arb_param_pkg::*;
#(
    parameter type T   = op_codes_e_t,
    parameter int  SEL = 2
);
    localparam int N = 2**SEL;

    T [N-1:0]       in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           force_en;
    logic [SEL-1:0] force_sel;
    T               out_data;
    logic [SEL-1:0] out_sel;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    grant_cnt;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid, grant_cnt
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid, grant_cnt
    );
endinterface

// File: rtl/mux_arb_param_pick.sv
// Combinational winner search over a request vector: scans N slots starting at
// ptr (round-robin) or at slot 0 (fixed priority) and returns the first request.
module rr_pick_param
    import mux_arb_param_pkg::*;
#(
    parameter int          SEL  = 2,
    parameter arb_mode_e_t MODE = ARB_RR
) (
    input  logic [2**SEL-1:0] req,
    input  logic [SEL-1:0]    ptr,
    output logic [SEL-1:0]    gnt_idx,
    output logic              gnt_any
);
    localparam int N = 2**SEL;

    logic [SEL-1:0] cand;

    // Candidate index wraps naturally in SEL bits because N is a power of two.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = (MODE == ARB_RR) ? ptr + SEL'(k) : SEL'(k);
            if (!gnt_any && req[cand]) begin
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_param.sv
// N-to-1 registered mux: arbitrates valid channels into a one-entry output register
// with valid/ready on both sides, optional forced channel, and an accept counter.
module mux_arb_param
    import mux_arb_param_pkg::*;
#(
    parameter type         T    = op_codes_e_t,
    parameter int          SEL  = 2,
    parameter arb_mode_e_t MODE = ARB_RR
) (
    input logic            clk,
    input logic            rst_n,
    mux_arb_param_if.slave bus
);
    localparam int unsigned N = 2**SEL;

    out_state_e     state, state_nxt;
    logic [N-1:0]   eligible, req;
    logic [SEL-1:0] rr_ptr, gnt_idx;
    logic           gnt_any, load;

    rr_pick_param #(.SEL(SEL), .MODE(MODE)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A full register only accepts when the consumer drains it in the same cycle.
    always_comb begin
        eligible     = bus.force_en ? (N'(1) << bus.force_sel) : '1;
        req          = bus.in_valid & eligible;
        load         = rst_n && ((state == EMPTY) || bus.out_ready) && gnt_any;
        bus.in_ready = load ? (N'(1) << gnt_idx) : '0;
        state_nxt    = state;
        case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL:  if (bus.out_ready && !gnt_any) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Payload and index are held after a drain; only a load rewrites them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_data  <= T'('0);
            bus.out_sel   <= '0;
            bus.grant_cnt <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            bus.out_data  <= bus.in_data[gnt_idx];
            bus.out_sel   <= gnt_idx;
            bus.grant_cnt <= bus.grant_cnt + 16'd1;
            if (MODE == ARB_RR) rr_ptr <= SEL'(next_rr_ptr(32'(gnt_idx), N));
        end
    end

    assign bus.out_valid = (state == FULL);
endmodule

// File: tb/tb_mux_arb_param.sv
// Scoreboard bench: instance A (op codes, round-robin) and instance B (memory
// control struct, fixed priority) driven with directed vectors.
module tb_mux_arb_param;
    import mux_arb_param_pkg::*;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk, rst_n;
    int   total = 0, bad = 0;
    exp_t qa[$], qb[$];

    op_codes_e_t a_dat [4];
    mem_ctl_st_t b_dat [4];

    mux_arb_param_if #(.T(op_codes_e_t), .SEL(2)) ifa ();
    mux_arb_param_if #(.T(mem_ctl_st_t), .SEL(2)) ifb ();

    mux_arb_param #(.T(op_codes_e_t), .SEL(2), .MODE(ARB_RR)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    mux_arb_param #(.T(mem_ctl_st_t), .SEL(2), .MODE(ARB_FIXED)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int ch, input logic [31:0] d);
        qa.push_back('{sel: 2'(ch), data: d});
    endtask

    task automatic push_b(input int ch);
        qb.push_back('{sel: 2'(ch), data: 32'({b_dat[ch]})});
    endtask

    // Monitors: every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected actual_sel=%0d required=no_output", ifa.out_sel);
            end else begin
                e = qa.pop_front();
                chk("a_sel", 32'(ifa.out_sel), 32'(e.sel));
                chk("a_data", 32'({ifa.out_data}), e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected actual_sel=%0d required=no_output", ifb.out_sel);
            end else begin
                e = qb.pop_front();
                chk("b_sel", 32'(ifb.out_sel), 32'(e.sel));
                chk("b_data", 32'({ifb.out_data}), e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_dat = '{OP_LD, OP_ST, OP_ADD, OP_SUB};
        b_dat = '{'{addr: 8'h10, we: 1'b0, be: 4'h1},
                  '{addr: 8'h11, we: 1'b1, be: 4'h2},
                  '{addr: 8'h12, we: 1'b0, be: 4'h4},
                  '{addr: 8'h13, we: 1'b1, be: 4'h8}};
        for (int i = 0; i < 4; i++) begin
            ifa.in_data[i] = a_dat[i];
            ifb.in_data[i] = b_dat[i];
        end
        rst_n = 1'b0;
        ifa.in_valid = 4'hF;  ifb.in_valid = 4'hF;
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        ifa.force_en = 1'b0;  ifb.force_en = 1'b0;
        ifa.force_sel = 2'd0; ifb.force_sel = 2'd0;

        // T1: reset with all channels valid, then first load picks ch0
        tick();
        #1 chk("a_rdy_rst", 32'(ifa.in_ready), 32'h0);
        chk("b_rdy_rst", 32'(ifb.in_ready), 32'h0);
        tick();
        chk("a_vld_rst", 32'(ifa.out_valid), 32'h0);
        chk("a_cnt_rst", 32'(ifa.grant_cnt), 32'h0);
        chk("b_vld_rst", 32'(ifb.out_valid), 32'h0);
        rst_n = 1'b1;
        #1 chk("a_rdy_first", 32'(ifa.in_ready), 32'h1);
        chk("b_rdy_first", 32'(ifb.in_ready), 32'h1);
        push_a(0, 32'(a_dat[0]));
        push_b(0);
        tick();
        ifa.in_valid = 4'h0; ifb.in_valid = 4'h0;
        tick();
        chk("a_cnt_1", 32'(ifa.grant_cnt), 32'h1);
        chk("a_vld_drain", 32'(ifa.out_valid), 32'h0);

        // T2: round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 chk("a_rdy_rr", 32'(ifa.in_ready), 32'h1 << (k % 4));
            push_a(k % 4, 32'(a_dat[k % 4]));
            tick();
        end
        ifa.in_valid = 4'h0;
        chk("a_cnt_8", 32'(ifa.grant_cnt), 32'h8);
        tick();

        // T3: fixed priority always grants ch1 of 4'b1010
        ifb.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1 chk("b_rdy_fix", 32'(ifb.in_ready), 32'h2);
            push_b(1);
            tick();
        end
        ifb.in_valid = 4'h0;
        tick();
        chk("b_cnt_4", 32'(ifb.grant_cnt), 32'h4);

        // T4: backpressure holds ch2 item, release reloads ch2 same cycle
        ifa.out_ready = 1'b0;
        ifa.in_valid = 4'b0100;
        #1 chk("a_rdy_bp_load", 32'(ifa.in_ready), 32'h4);
        push_a(2, 32'(OP_ADD));
        tick();
        ifa.in_data[2] = OP_AND;
        repeat (3) begin
            #1 chk("a_rdy_bp", 32'(ifa.in_ready), 32'h0);
            chk("a_dat_bp", 32'({ifa.out_data}), 32'(OP_ADD));
            tick();
        end
        ifa.out_ready = 1'b1;
        #1 chk("a_rdy_bp_rel", 32'(ifa.in_ready), 32'h4);
        push_a(2, 32'(OP_AND));
        tick();
        ifa.in_valid = 4'h0;
        tick();
        ifa.in_data[2] = OP_ADD;

        // T5: force ch3; non-eligible valids must not load
        ifa.in_valid = 4'b0001;
        push_a(0, 32'(OP_LD));
        tick();
        ifa.force_en = 1'b1;
        ifa.force_sel = 2'd3;
        ifa.in_valid = 4'b0111;
        #1 chk("a_rdy_force_none", 32'(ifa.in_ready), 32'h0);
        tick();
        chk("a_vld_force", 32'(ifa.out_valid), 32'h0);
        chk("a_sel_held", 32'(ifa.out_sel), 32'h0);
        chk("a_dat_held", 32'({ifa.out_data}), 32'(OP_LD));
        ifa.in_valid = 4'hF;
        #1 chk("a_rdy_force3", 32'(ifa.in_ready), 32'h8);
        push_a(3, 32'(OP_SUB));
        tick();
        chk("a_vld_force3", 32'(ifa.out_valid), 32'h1);
        chk("a_sel_force3", 32'(ifa.out_sel), 32'h3);
        ifa.in_valid = 4'h0;
        ifa.force_en = 1'b0;
        tick();

        // T6: counter wrap, then reset while full discards the held item
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifa.in_valid = 4'hF;
        for (int i = 0; i < 65536; i++) begin
            push_a(i % 4, 32'(a_dat[i % 4]));
            tick();
            if (i == 65534) chk("a_cnt_ffff", 32'(ifa.grant_cnt), 32'hFFFF);
        end
        ifa.in_valid = 4'h0;
        ifa.out_ready = 1'b0;
        chk("a_cnt_wrap", 32'(ifa.grant_cnt), 32'h0);
        tick();
        chk("a_vld_hold", 32'(ifa.out_valid), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("a_vld_midrst", 32'(ifa.out_valid), 32'h0);
        chk("a_q_held", 32'(qa.size()), 32'h1);
        if (qa.size() != 0) void'(qa.pop_front());
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        tick();
        tick();
        chk("a_q_empty", 32'(qa.size()), 32'h0);
        chk("b_q_empty", 32'(qb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
